// File: rtl/result_checker.sv
// Post-run result checker: runs the CPU for a fixed number of cycles, then freezes it
// and walks a table of expected register / data-memory values, tallying pass and fail.
module result_checker #(
    parameter int unsigned RUN_CYCLES = 1000,
    parameter int unsigned NUM_CHECKS = 8
) (
    input  logic        clk,
    input  logic        reset,
    output logic        cpu_reset,
    output logic        cpu_en,
    output logic [7:0]  chk_idx,
    input  logic        chk_kind,
    input  logic [5:0]  chk_sel,
    input  logic [31:0] chk_exp,
    output logic [3:0]  rf_ra,
    input  logic [31:0] rf_rd,
    output logic [5:0]  mem_ra,
    input  logic [31:0] mem_rd,
    output logic [7:0]  pass_cnt,
    output logic [7:0]  fail_cnt,
    output logic [7:0]  first_fail_idx,
    output logic [31:0] first_fail_val,
    output logic        done,
    output logic        all_pass
);

    localparam int unsigned DATA_W = 32;
    localparam logic [19:0] RUN_LAST = 20'(RUN_CYCLES - 1);
    localparam logic [7:0]  LAST_IDX = 8'(NUM_CHECKS - 1);

    typedef enum logic [2:0] {HOLD, RUN, FETCH, COMPARE, DONE} state_t;

    state_t            state;
    logic [19:0]       run_cnt;
    logic [7:0]        idx;
    logic              kind_p1;
    logic [DATA_W-1:0] exp_p1;
    logic [DATA_W-1:0] obs_p1;
    logic              match_p1;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // The CPU is enabled during the HOLD cycle too (it sits in its own reset then),
    // but never while our reset is asserted.
    assign cpu_en = (state == RUN) || ((state == HOLD) && !reset);

    // Stage p1: entry captured in FETCH, debug read data selected during COMPARE
    assign obs_p1   = kind_p1 ? mem_rd : rf_rd;
    assign match_p1 = (obs_p1 == exp_p1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= HOLD;
            cpu_reset      <= 1'b1;
            chk_idx        <= 8'd0;
            rf_ra          <= 4'd0;
            mem_ra         <= 6'd0;
            pass_cnt       <= 8'd0;
            fail_cnt       <= 8'd0;
            first_fail_idx <= 8'hFF;
            first_fail_val <= '0;
            done           <= 1'b0;
            all_pass       <= 1'b0;
            run_cnt        <= 20'd0;
            idx            <= 8'd0;
        end else begin
            case (state)
                HOLD: begin
                    cpu_reset <= 1'b0;
                    run_cnt   <= 20'd0;
                    state     <= RUN;
                end
                RUN: begin
                    if (run_cnt == RUN_LAST) begin
                        if (NUM_CHECKS == 0) begin
                            state    <= DONE;
                            done     <= 1'b1;
                            all_pass <= (fail_cnt == 8'd0);
                        end else begin
                            idx     <= 8'd0;
                            chk_idx <= 8'd0;
                            state   <= FETCH;
                        end
                    end else begin
                        run_cnt <= run_cnt + 20'd1;
                    end
                end
                FETCH: begin
                    kind_p1 <= chk_kind;
                    exp_p1  <= chk_exp;
                    rf_ra   <= chk_sel[3:0];
                    mem_ra  <= chk_sel;
                    chk_idx <= 8'd0;
                    state   <= COMPARE;
                end
                COMPARE: begin
                    rf_ra  <= 4'd0;
                    mem_ra <= 6'd0;
                    if (match_p1) begin
                        pass_cnt <= sat_inc(pass_cnt);
                    end else begin
                        fail_cnt <= sat_inc(fail_cnt);
                        if (fail_cnt == 8'd0) begin
                            first_fail_idx <= idx;
                            first_fail_val <= obs_p1;
                        end
                    end
                    if (idx == LAST_IDX) begin
                        state    <= DONE;
                        done     <= 1'b1;
                        all_pass <= match_p1 && (fail_cnt == 8'd0);
                    end else begin
                        idx     <= idx + 8'd1;
                        chk_idx <= idx + 8'd1;
                        state   <= FETCH;
                    end
                end
                DONE: begin
                    state <= DONE;
                end
                default: state <= HOLD;
            endcase
        end
    end

endmodule

// File: tb/tb_result_checker.sv
// Bench for result_checker: stub register file / data memory with a counting "CPU"
// scratch location, directed and randomized check tables, and a table-walking model.
module tb_result_checker;

    localparam int RUN  = 1000;
    localparam int NCH  = 8;
    localparam int ZRUN = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic        cpu_reset, cpu_en, chk_kind, done, all_pass;
    logic [7:0]  chk_idx, pass_cnt, fail_cnt, first_fail_idx;
    logic [5:0]  chk_sel, mem_ra;
    logic [3:0]  rf_ra;
    logic [31:0] chk_exp, rf_rd, mem_rd, first_fail_val;

    logic        z_cpu_reset, z_cpu_en, z_done, z_all_pass;
    logic [7:0]  z_chk_idx, z_pass_cnt, z_fail_cnt, z_first_fail_idx;
    logic [5:0]  z_mem_ra;
    logic [3:0]  z_rf_ra;
    logic [31:0] z_rf_rd, z_mem_rd, z_first_fail_val;

    logic [31:0] rf [16];
    logic [31:0] mem[64];
    logic [31:0] scratch;
    logic        tk[NCH];
    logic [5:0]  ts[NCH];
    logic [31:0] te[NCH];

    int passed = 0;
    int total  = 0;

    // Stub CPU: rf[15] and mem[63] both alias a counter that advances on every enabled,
    // non-reset cycle, so it ends a run holding RUN.
    always @(posedge clk) begin
        if (cpu_reset) scratch <= 32'd0;
        else if (cpu_en) scratch <= scratch + 32'd1;
    end

    assign chk_kind = tk[chk_idx[2:0]];
    assign chk_sel  = ts[chk_idx[2:0]];
    assign chk_exp  = te[chk_idx[2:0]];
    assign rf_rd    = (rf_ra == 4'd15) ? scratch : rf[rf_ra];
    assign mem_rd   = (mem_ra == 6'd63) ? scratch : mem[mem_ra];
    assign z_rf_rd  = rf[z_rf_ra];
    assign z_mem_rd = mem[z_mem_ra];

    result_checker #(.RUN_CYCLES(RUN), .NUM_CHECKS(NCH)) u_dut (
        .clk(clk), .reset(reset), .cpu_reset(cpu_reset), .cpu_en(cpu_en),
        .chk_idx(chk_idx), .chk_kind(chk_kind), .chk_sel(chk_sel), .chk_exp(chk_exp),
        .rf_ra(rf_ra), .rf_rd(rf_rd), .mem_ra(mem_ra), .mem_rd(mem_rd),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .first_fail_idx(first_fail_idx),
        .first_fail_val(first_fail_val), .done(done), .all_pass(all_pass)
    );

    result_checker #(.RUN_CYCLES(ZRUN), .NUM_CHECKS(0)) u_zero (
        .clk(clk), .reset(reset), .cpu_reset(z_cpu_reset), .cpu_en(z_cpu_en),
        .chk_idx(z_chk_idx), .chk_kind(1'b0), .chk_sel(6'd0), .chk_exp(32'd0),
        .rf_ra(z_rf_ra), .rf_rd(z_rf_rd), .mem_ra(z_mem_ra), .mem_rd(z_mem_rd),
        .pass_cnt(z_pass_cnt), .fail_cnt(z_fail_cnt), .first_fail_idx(z_first_fail_idx),
        .first_fail_val(z_first_fail_val), .done(z_done), .all_pass(z_all_pass)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Value the table entry should find once the stub CPU has run RUN cycles.
    function automatic logic [31:0] ref_val(input logic k, input logic [5:0] s);
        logic [3:0] r;
        r = s[3:0];
        if (!k) return (r == 4'd15) ? 32'(RUN) : rf[r];
        return (s == 6'd63) ? 32'(RUN) : mem[s];
    endfunction

    task automatic check_reset_vals(input string sc);
        check({sc, " rst cpu_reset"}, 32'(cpu_reset), 32'd1);
        check({sc, " rst cpu_en"}, 32'(cpu_en), 32'd0);
        check({sc, " rst chk_idx"}, 32'(chk_idx), 32'd0);
        check({sc, " rst rf_ra"}, 32'(rf_ra), 32'd0);
        check({sc, " rst mem_ra"}, 32'(mem_ra), 32'd0);
        check({sc, " rst pass_cnt"}, 32'(pass_cnt), 32'd0);
        check({sc, " rst fail_cnt"}, 32'(fail_cnt), 32'd0);
        check({sc, " rst ffi"}, 32'(first_fail_idx), 32'hFF);
        check({sc, " rst ffv"}, first_fail_val, 32'd0);
        check({sc, " rst done"}, 32'(done), 32'd0);
        check({sc, " rst all_pass"}, 32'(all_pass), 32'd0);
    endtask

    // Leaves the bench 1 time unit into cycle 0, the first cycle with reset low.
    task automatic release_reset(input string sc);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals(sc);
        reset = 1'b0;
    endtask

    task automatic monitor_run(input string sc);
        int c;
        int en;
        logic [31:0] snap;
        bit snapped;
        c = 0; en = 0; snap = 'x; snapped = 0;
        forever begin
            @(negedge clk);
            if (done) break;
            if (cpu_en) en++;
            else if (!snapped) begin
                snap = scratch;
                snapped = 1;
            end
            c++;
            if (c > 4 * (RUN + 2 * NCH)) break;
        end
        check({sc, " done_cycle"}, 32'(c), 32'(1 + RUN + 2 * NCH));
        check({sc, " cpu_en_cycles"}, 32'(en), 32'(1 + RUN));
        check({sc, " cpu_en_at_done"}, 32'(cpu_en), 32'd0);
        check({sc, " frozen_state"}, scratch, snap);
        check({sc, " idle_addr"}, {12'd0, chk_idx, rf_ra, mem_ra}, 32'd0);
    endtask

    task automatic expect_results(input string sc);
        int ep, ef;
        logic [7:0]  fi;
        logic [31:0] fv, v;
        ep = 0; ef = 0; fi = 8'hFF; fv = 32'd0;
        for (int i = 0; i < NCH; i++) begin
            v = ref_val(tk[i], ts[i]);
            if (v === te[i]) ep++;
            else begin
                if (ef == 0) begin
                    fi = 8'(i);
                    fv = v;
                end
                ef++;
            end
        end
        check({sc, " pass_cnt"}, 32'(pass_cnt), 32'(ep));
        check({sc, " fail_cnt"}, 32'(fail_cnt), 32'(ef));
        check({sc, " first_fail_idx"}, 32'(first_fail_idx), 32'(fi));
        check({sc, " first_fail_val"}, first_fail_val, fv);
        check({sc, " all_pass"}, 32'(all_pass), 32'(ef == 0));
        check({sc, " done"}, 32'(done), 32'd1);
    endtask

    task automatic load_program_table();
        for (int i = 0; i < 16; i++) rf[i] = $urandom;
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        rf[0] = 0; rf[3] = 12; rf[4] = 7; rf[5] = 11; rf[7] = 7; rf[2] = 7;
        mem[24] = 7; mem[25] = 7;
        tk[0] = 0; ts[0] = 6'd0;  te[0] = 32'd0;
        tk[1] = 0; ts[1] = 6'd3;  te[1] = 32'd12;
        tk[2] = 0; ts[2] = 6'd4;  te[2] = 32'd7;
        tk[3] = 0; ts[3] = 6'd5;  te[3] = 32'd11;
        tk[4] = 0; ts[4] = 6'd7;  te[4] = 32'd7;
        tk[5] = 0; ts[5] = 6'd2;  te[5] = 32'd7;
        tk[6] = 1; ts[6] = 6'd24; te[6] = 32'd7;
        tk[7] = 1; ts[7] = 6'd25; te[7] = 32'd7;
    endtask

    initial begin
        int c;
        bit zbad;
        load_program_table();

        // Scenario 4: zero-entry table on the second instance
        release_reset("s4");
        c = 0; zbad = 0;
        forever begin
            @(negedge clk);
            if (z_done) break;
            if (z_chk_idx != 8'd0) zbad = 1;
            c++;
            if (c > 50) break;
        end
        check("s4 done_cycle", 32'(c), 32'(1 + ZRUN));
        check("s4 all_pass", 32'(z_all_pass), 32'd1);
        check("s4 chk_idx_stuck_0", 32'(zbad || (z_chk_idx != 8'd0)), 32'd0);
        check("s4 counts", {16'd0, z_pass_cnt, z_fail_cnt}, 32'd0);
        check("s4 first_fail", {z_first_fail_idx, 24'd0} | z_first_fail_val, 32'hFF000000);
        check("s4 cpu_ctl", {30'd0, z_cpu_reset, z_cpu_en}, 32'd0);

        // Scenario 1 + 6: program table, all entries pass, cpu_en monitored
        release_reset("s1");
        monitor_run("s1");
        expect_results("s1");
        check("s1 pass_cnt_lit", 32'(pass_cnt), 32'd8);

        // Scenario 2: entry 3 expectation wrong
        te[3] = 32'd12;
        release_reset("s2");
        monitor_run("s2");
        expect_results("s2");
        check("s2 ffv_lit", first_fail_val, 32'd11);
        te[3] = 32'd11;

        // Scenario 3: random tables, entries 2 and 5 forced wrong
        for (int t = 0; t < 2; t++) begin
            for (int i = 0; i < 16; i++) rf[i] = $urandom;
            for (int i = 0; i < 64; i++) mem[i] = $urandom;
            for (int i = 0; i < NCH; i++) begin
                tk[i] = 1'($urandom_range(0, 1));
                ts[i] = 6'($urandom_range(0, 63));
                te[i] = ref_val(tk[i], ts[i]);
                if (i == 2 || i == 5) te[i] = te[i] ^ ($urandom | 32'd1);
            end
            release_reset("s3");
            monitor_run("s3");
            expect_results("s3");
            check("s3 ffi_lit", 32'(first_fail_idx), 32'd2);
        end

        // Randomized mix: each entry wrong with probability about one third
        for (int i = 0; i < NCH; i++) begin
            tk[i] = 1'($urandom_range(0, 1));
            ts[i] = 6'($urandom_range(0, 63));
            te[i] = ref_val(tk[i], ts[i]);
            if ($urandom_range(0, 2) == 0) te[i] = te[i] + 32'($urandom_range(1, 1000));
        end
        release_reset("rnd");
        monitor_run("rnd");
        expect_results("rnd");

        // Scenario 5: reset pulse during COMPARE of entry 4
        load_program_table();
        release_reset("s5a");
        repeat (RUN + 10) @(posedge clk);
        #1;
        check("s5 mid pass_cnt", 32'(pass_cnt), 32'd4);
        check("s5 mid rf_ra", 32'(rf_ra), 32'd7);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_reset_vals("s5b");
        reset = 1'b0;
        monitor_run("s5");
        expect_results("s5");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/result_checker.md
RESULT_CHECKER -- requirements
Module: result_checker

Interface
REQ-001 Parameter: RUN_CYCLES, default 1000, number of cycles the CPU is enabled before checking starts (legal range 1..2^20-1).
REQ-002 Parameter: NUM_CHECKS, default 8, number of check-table entries evaluated (legal range 0..255).
REQ-003 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: cpu_reset  output  1  reset driven into the CPU top.
REQ-006 Port: cpu_en  output  1  CPU state-update enable; 0 freezes the register file, PC and data memory.
REQ-007 Port: chk_idx  output  8  check-table entry index being fetched.
REQ-008 Port: chk_kind  input  1  table entry type: 0 = register, 1 = data-memory word.
REQ-009 Port: chk_sel  input  6  register number (bits 3:0 used) or data-memory word index.
REQ-010 Port: chk_exp  input  32  expected value for the entry.
REQ-011 Port: rf_ra  output  4  register-file debug read address.
REQ-012 Port: rf_rd  input  32  register-file debug read data, combinational from rf_ra.
REQ-013 Port: mem_ra  output  6  data-memory debug word address.
REQ-014 Port: mem_rd  input  32  data-memory debug read data, combinational from mem_ra.
REQ-015 Port: pass_cnt  output  8  number of passing checks.
REQ-016 Port: fail_cnt  output  8  number of failing checks.
REQ-017 Port: first_fail_idx  output  8  index of the first failing entry; 8'hFF if none.
REQ-018 Port: first_fail_val  output  32  value actually read for the first failing entry; 0 if none.
REQ-019 Port: done  output  1  checking complete; held high until reset.
REQ-020 Port: all_pass  output  1  done and fail_cnt == 0.

Function
REQ-021 FSM states: HOLD, RUN, FETCH, COMPARE, DONE.
REQ-022 HOLD lasts exactly 1 cycle:
  - cpu_reset=1, cpu_en=1
  - next state RUN
REQ-023 RUN:
  - cpu_reset=0, cpu_en=1
  - cycle counter counts from 0
  - after RUN_CYCLES cycles in RUN, go to FETCH; if NUM_CHECKS==0, go to DONE instead
REQ-024 FETCH:
  - cpu_en=0
  - chk_idx = current entry index
  - register chk_kind, chk_sel, chk_exp at end of cycle
  - next state COMPARE
REQ-025 COMPARE:
  - cpu_en=0
  - drive rf_ra = registered chk_sel[3:0] and mem_ra = registered chk_sel
  - select rf_rd (kind 0) or mem_rd (kind 1)
  - compare all 32 bits against the registered chk_exp
  - update counters at end of cycle
REQ-026 On a match, pass_cnt increments by 1.
REQ-027 On a mismatch, fail_cnt increments by 1; on the first mismatch only, capture first_fail_idx and first_fail_val.
REQ-028 After COMPARE of entry NUM_CHECKS-1, go to DONE; otherwise increment the index and go to FETCH.
REQ-029 DONE:
  - cpu_en=0, cpu_reset=0, done=1, all_pass = (fail_cnt==0)
  - state holds until reset
REQ-030 Timing: each check costs exactly 2 cycles, so done rises 1+RUN_CYCLES+2*NUM_CHECKS cycles after the first cycle with reset low.
REQ-031 Counters saturate at 255; pass_cnt+fail_cnt == NUM_CHECKS at done.
REQ-032 rf_ra, mem_ra and chk_idx are 0 outside their active states.

Reset
REQ-033 While reset=1, every output takes its reset value on each clock edge:
  - state=HOLD
  - cpu_reset=1, cpu_en=0
  - chk_idx, rf_ra, mem_ra = 0
  - pass_cnt, fail_cnt = 0
  - first_fail_idx=8'hFF, first_fail_val=0
  - done=0, all_pass=0
REQ-034 Reset asserted in any state, including mid-check, aborts the sequence; the run restarts from HOLD when reset falls.

Verification
REQ-035 Scenario 1, 8-entry table against the CPU top program:
  - entries: R0=0, R3=12, R4=7, R5=11, R7=7, R2=7, mem[24]=7, mem[25]=7
  - run with RUN_CYCLES=1000
  - required: done at cycle 1017; pass_cnt=8, fail_cnt=0, all_pass=1, first_fail_idx=8'hFF
REQ-036 Scenario 2, Scenario 1 with entry 3 expected value changed to 12:
  - required: pass_cnt=7, fail_cnt=1, first_fail_idx=3, first_fail_val=11, all_pass=0
REQ-037 Scenario 3, two failing entries (2 and 5) against a stub RF/memory:
  - required: fail_cnt=2, first_fail_idx=2 (not overwritten by entry 5)
REQ-038 Scenario 4, NUM_CHECKS=0, RUN_CYCLES=4:
  - required: done at cycle 5, all_pass=1, chk_idx never leaves 0
REQ-039 Scenario 5, reset pulsed for 1 cycle during COMPARE of entry 4:
  - required: all outputs return to reset values; full sequence reruns and done rises 1+RUN_CYCLES+2*NUM_CHECKS cycles after reset falls
REQ-040 Scenario 6, cpu_en monitor across a full run:
  - required: cpu_en=1 for exactly 1+RUN_CYCLES cycles and 0 for every cycle in FETCH, COMPARE and DONE
  - required: stub register and memory contents unchanged while cpu_en=0
